// File: rtl/reorder_buffer.sv
// In-order retirement buffer behind rename: records rd/prd_new/prd_old per instruction,
// tracks out-of-order completion, and retires one entry per cycle in program order.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_valid,
  input  logic              dispatch_has_rd,
  input  logic [4:0]        dispatch_rd,
  input  logic [PREG_W-1:0] dispatch_prd_new,
  input  logic [PREG_W-1:0] dispatch_prd_old,
  output logic              dispatch_ready,
  output logic [TAG_W-1:0]  dispatch_tag,
  input  logic              complete_valid,
  input  logic [TAG_W-1:0]  complete_tag,
  output logic              commit_valid,
  output logic [4:0]        commit_rd,
  output logic [PREG_W-1:0] commit_prd_new,
  output logic [PREG_W-1:0] commit_prd_old,
  output logic              commit_free,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_has_rd;
  logic [4:0]        r_rd      [DEPTH];
  logic [PREG_W-1:0] r_prd_new [DEPTH];
  logic [PREG_W-1:0] r_prd_old [DEPTH];
  logic [TAG_W:0]    r_head;
  logic [TAG_W:0]    r_tail;

  logic              r_commit_valid;
  logic              r_commit_free;
  logic [4:0]        r_commit_rd;
  logic [PREG_W-1:0] r_commit_prd_new;
  logic [PREG_W-1:0] r_commit_prd_old;

  logic [DEPTH-1:0]  w_valid_next;
  logic [DEPTH-1:0]  w_done_next;
  logic [TAG_W-1:0]  w_head_idx;
  logic [TAG_W-1:0]  w_tail_idx;
  logic              w_full;
  logic              w_dispatch;
  logic              w_retire;

  assign w_head_idx = r_head[TAG_W-1:0];
  assign w_tail_idx = r_tail[TAG_W-1:0];
  // Same index with differing wrap bits means the tail has lapped the head.
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);
  assign w_dispatch = dispatch_valid && !w_full;
  assign w_retire   = r_valid[w_head_idx] && r_done[w_head_idx];

  assign full           = w_full;
  assign empty          = (r_head == r_tail);
  assign count          = r_tail - r_head;
  assign dispatch_ready = !w_full;
  assign dispatch_tag   = w_tail_idx;

  assign commit_valid   = r_commit_valid;
  assign commit_free    = r_commit_free;
  assign commit_rd      = r_commit_rd;
  assign commit_prd_new = r_commit_prd_new;
  assign commit_prd_old = r_commit_prd_old;

  // Dispatch and retire never target the same slot: that needs full (no dispatch)
  // or empty (head invalid, no retire).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic w_is_tail;
      logic w_is_head;
      logic w_is_cmpl;
      assign w_is_tail = w_dispatch && (w_tail_idx == TAG_W'(gi));
      assign w_is_head = w_retire && (w_head_idx == TAG_W'(gi));
      assign w_is_cmpl = complete_valid && (complete_tag == TAG_W'(gi)) && r_valid[gi];
      assign w_valid_next[gi] = w_is_tail ? 1'b1 : (w_is_head ? 1'b0 : r_valid[gi]);
      assign w_done_next[gi]  = (w_is_tail || w_is_head) ? 1'b0 :
                                (w_is_cmpl ? 1'b1 : r_done[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
      r_head  <= r_head + {{TAG_W{1'b0}}, w_retire};
      r_tail  <= r_tail + {{TAG_W{1'b0}}, w_dispatch};
    end
  end

  // Payload storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_dispatch) begin
      r_has_rd[w_tail_idx]  <= dispatch_has_rd;
      r_rd[w_tail_idx]      <= dispatch_rd;
      r_prd_new[w_tail_idx] <= dispatch_prd_new;
      r_prd_old[w_tail_idx] <= dispatch_prd_old;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_valid   <= 1'b0;
      r_commit_free    <= 1'b0;
      r_commit_rd      <= '0;
      r_commit_prd_new <= '0;
      r_commit_prd_old <= '0;
    end else if (flush) begin
      r_commit_valid <= 1'b0;
      r_commit_free  <= 1'b0;
    end else if (w_retire) begin
      r_commit_valid   <= 1'b1;
      r_commit_rd      <= r_rd[w_head_idx];
      r_commit_prd_new <= r_prd_new[w_head_idx];
      r_commit_prd_old <= r_prd_old[w_head_idx];
      // Physical register 0 is hardwired and never returns to the free list.
      r_commit_free    <= r_has_rd[w_head_idx] && (r_prd_old[w_head_idx] != '0);
    end else begin
      r_commit_valid <= 1'b0;
      r_commit_free  <= 1'b0;
    end
  end

endmodule
